// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture on N_CH level inputs with round-robin arbitration
// onto a single valid/ready event port, plus sticky per-channel loss flags.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | nothing offered, evt_valid=0
// OFFER | evt_id held on the port until evt_ready accepts
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] level_in,
  input  logic            evt_ready,
  input  logic            ovf_clr,
  output logic            evt_valid,
  output logic [IDW-1:0]  evt_id,
  output logic [N_CH-1:0] overflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [N_CH-1:0] prev;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] grant_oh;
  logic [N_CH-1:0] grant_take;
  logic [N_CH-1:0] ovf_set;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_found;
  logic            transfer;
  logic            do_grant;

  assign evt_valid = (state == OFFER);
  assign transfer  = evt_valid & evt_ready;
  assign rise      = level_in & ~prev;

  // Two passes: channels above last_grant first, then wrap to the low end.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_oh    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_found && pending[i] && (i > int'(last_grant))) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
        grant_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_found && pending[i] && (i <= int'(last_grant))) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign do_grant   = grant_found & ((state == IDLE) | transfer);
  assign grant_take = grant_oh & {N_CH{do_grant}};
  // A channel being granted this edge frees its slot, so a coincident edge is not a loss.
  assign ovf_set    = rise & pending & ~grant_take;

  always_comb begin
    state_nxt = state;
    if (do_grant) begin
      state_nxt = OFFER;
    end else if (transfer) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      pending    <= '0;
      overflow   <= '0;
      evt_id     <= '0;
      last_grant <= IDW'(N_CH - 1);
    end else begin
      state    <= state_nxt;
      prev     <= level_in;
      pending  <= (pending & ~grant_take) | rise;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
      if (do_grant) begin
        evt_id     <= grant_id;
        last_grant <= grant_id;
      end
    end
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of level input channels (legal range 2..16).
REQ-002 The block SHALL have parameter IDW, default 2, giving the channel-ID width; IDW SHALL equal ceil(log2(N_CH)).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; when rst=0 at a rising clk edge, all state SHALL take its reset value.
REQ-005 level_in  input  N_CH  asynchronous-origin levels, one per channel, sampled on clk (already synchronized upstream).
REQ-006 evt_ready  input  1  downstream consumer can accept an event this cycle.
REQ-007 ovf_clr  input  1  single-cycle request to clear all overflow flags.
REQ-008 evt_valid  output  1  an event is offered on evt_id.
REQ-009 evt_id  output  IDW  channel number of the offered event.
REQ-010 overflow  output  N_CH  sticky per-channel flag: an event was lost.

Function
REQ-011 Per channel: prev[i] SHALL register level_in[i] every cycle; a rising edge SHALL be detected when level_in[i]=1 and prev[i]=0.
REQ-012 A detected edge SHALL set pending[i] at the same clock edge on which it is detected.
REQ-013 The FSM SHALL have two states: IDLE (evt_valid=0) and OFFER (evt_valid=1).
REQ-014 IDLE -> OFFER when any pending bit is 1: evt_id SHALL load the granted channel and that pending bit SHALL clear on the same edge.
REQ-015 Grant selection SHALL be round-robin: search starts at (last_grant+1) mod N_CH, wraps, and takes the first pending channel; last_grant SHALL update on every grant.
REQ-016 Latency: level_in first sampled high at edge k -> pending set at edge k -> evt_valid=1 after edge k+1 (IDLE, no competition).
REQ-017 In OFFER, evt_valid and evt_id SHALL hold stable until evt_valid=1 and evt_ready=1 at a rising edge (transfer).
REQ-018 On transfer with other pending bits set, the FSM SHALL stay in OFFER and load the next round-robin grant on the same edge (back-to-back, no bubble).
REQ-019 On transfer with no pending bits set, the FSM SHALL go to IDLE.
REQ-020 evt_ready while evt_valid=0 SHALL have no effect.
REQ-021 An edge on channel i while pending[i]=1 and channel i is not being granted that edge SHALL set overflow[i]; pending[i] stays 1 (events coalesce).
REQ-022 An edge on channel i on the same edge that grants channel i SHALL leave pending[i]=1 and SHALL NOT set overflow[i].
REQ-023 An edge on the channel currently offered (already granted, pending=0) SHALL set pending; no overflow.
REQ-024 ovf_clr=1 SHALL clear all overflow bits; a same-edge overflow set on channel i SHALL win over the clear for that bit.
REQ-025 All outputs SHALL be registered; no combinational path from level_in or evt_ready to any output.

Reset
REQ-026 On reset: prev=0, pending=0, overflow=0, evt_valid=0, evt_id=0, last_grant=N_CH-1 (first search starts at channel 0), FSM=IDLE.
REQ-027 Reset SHALL take precedence over all other inputs, including mid-OFFER; the offered event is discarded.
REQ-028 Because prev resets to 0, a level held high through reset release SHALL produce one event on the first cycle out of reset.

Verification
REQ-029 Single event: N_CH=4, evt_ready=1, level_in 0000->0100 at edge k -> evt_valid=1, evt_id=2 for exactly one cycle after edge k+1; no further events while the level stays high.
REQ-030 Round-robin: level_in 0000->1111 in one cycle, evt_ready=1 -> evt_id sequence 0,1,2,3 on four consecutive cycles, evt_valid continuously 1, then 0.
REQ-031 Backpressure: an event is offered with evt_ready=0 for 5 cycles -> evt_valid/evt_id stable for all 5; transfer on the first cycle with ready=1.
REQ-032 Overflow: evt_ready=0, channel 1 pulses twice while channel 0 is offered -> overflow=0010; ovf_clr -> 0000; a same-cycle ovf_clr plus a new overflow -> bit stays 1.
REQ-033 Regrant race: channel 3 edge on the edge it is granted -> no overflow; channel 3 is offered again after the current transfer.
REQ-034 Reset mid-OFFER with pending=0110 and level_in=0001 held -> all cleared; after release, channel 0 is offered (evt_id=0) with no events for channels 1 and 2.
